// File: rtl/sha_msg_mem.sv
// Message buffer for a SHA-256 style core: loads a byte message word by word,
// then serves it back with the SHA padding and 64-bit length applied on the fly.
module sha_msg_mem #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_vld,
  output logic        wr_rdy,
  input  logic [31:0] wr_data,
  input  logic        wr_last,
  input  logic [2:0]  wr_bytes,
  input  logic        clr,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_data_vld,
  output logic        msg_rdy,
  output logic [15:0] msg_blocks,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: a loader word transfers on a rising edge where wr_vld && wr_rdy;
  // wr_vld may be held or dropped freely, wr_rdy never depends on wr_vld.
  localparam int CW = $clog2(DEPTH_WORDS + 1);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [15:0]   len;
  logic [31:0]   buf_mem [DEPTH_WORDS];

  logic        wr_acc;
  logic        full;
  logic [2:0]  last_bytes;
  logic [2:0]  add_bytes;
  logic        overflow;
  logic [15:0] len_nxt;
  logic [16:0] len_sum;
  logic [15:0] blocks_nxt;

  logic [31:0] rd_base;
  logic [29:0] rd_widx;
  logic [31:0] rd_word;
  logic [31:0] pad_word;

  assign wr_rdy    = (state == ST_LOAD);
  assign msg_rdy   = (state == ST_READY);
  assign err       = (state == ST_ERR);
  assign dbg_state = state;

  assign wr_acc     = wr_vld && (state == ST_LOAD) && !clr;
  assign full       = (cnt == CW'(DEPTH_WORDS));
  assign last_bytes = (wr_bytes > 3'd4) ? 3'd4 : wr_bytes;
  assign add_bytes  = wr_last ? last_bytes : 3'd4;
  // An empty final word still fits when the buffer is exactly full.
  assign overflow   = full && (add_bytes != 3'd0);
  assign len_nxt    = len + {13'd0, add_bytes};
  assign len_sum    = {1'b0, len_nxt} + 17'd8;
  assign blocks_nxt = {5'd0, len_sum[16:6]} + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      len        <= '0;
      msg_blocks <= '0;
    end else if (clr) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      len        <= '0;
      msg_blocks <= '0;
    end else if (state == ST_LOAD && wr_vld) begin
      if (overflow) begin
        state <= ST_ERR;
      end else begin
        if (!full) cnt <= cnt + CW'(1);
        len <= len_nxt;
        if (wr_last) begin
          state      <= ST_READY;
          msg_blocks <= blocks_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !full) buf_mem[cnt[AW-1:0]] <= wr_data;
  end

  // Byte b of the padded message view.
  function automatic logic [7:0] pad_byte(input logic [31:0] b, input logic [7:0] stored,
                                          input logic [15:0] l, input logic [15:0] blocks);
    logic [32:0] b33, l33, n33, sh33;
    logic [63:0] bitlen, shifted;
    b33    = {1'b0, b};
    l33    = {17'd0, l};
    n33    = {11'd0, blocks, 6'd0};
    bitlen = {45'd0, l, 3'd0};
    sh33   = n33 - 33'd1 - b33;
    shifted = bitlen >> {sh33[2:0], 3'b000};
    if (b33 < l33)              return stored;
    else if (b33 == l33)        return 8'h80;
    else if (b33 + 33'd8 < n33) return 8'h00;
    else if (b33 < n33)         return shifted[7:0];
    else                        return 8'h00;
  endfunction

  assign rd_base = mem_addr & ~32'd3;
  assign rd_widx = rd_base[31:2];

  always_comb begin
    rd_word = '0;
    if (state == ST_READY && rd_widx < 30'(DEPTH_WORDS)) rd_word = buf_mem[rd_widx[AW-1:0]];
  end

  always_comb begin
    pad_word = '0;
    for (int k = 0; k < 4; k++) begin
      pad_word[8*k +: 8] = pad_byte(rd_base + 32'(k), rd_word[8*k +: 8], len, msg_blocks);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data     <= '0;
      mem_data_vld <= 1'b0;
    end else if (clr || state != ST_READY) begin
      mem_data     <= '0;
      mem_data_vld <= 1'b0;
    end else begin
      mem_data     <= pad_word;
      mem_data_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha_msg_mem.sv
// Directed bench for sha_msg_mem: a read driver queues expected padded words,
// a negedge monitor compares them against mem_data whenever mem_data_vld is high.
module tb_sha_msg_mem;

  logic        clk;
  logic        rst_n;
  logic        wr_vld, wr_last, clr;
  logic [31:0] wr_data, mem_addr;
  logic [2:0]  wr_bytes;
  logic        wr_rdy, mem_data_vld, msg_rdy, err;
  logic [31:0] mem_data;
  logic [15:0] msg_blocks;
  logic [1:0]  dbg_state;

  logic        s_wr_vld, s_wr_last, s_clr;
  logic [31:0] s_wr_data, s_mem_addr;
  logic [2:0]  s_wr_bytes;
  logic        s_wr_rdy, s_mem_data_vld, s_msg_rdy, s_err;
  logic [31:0] s_mem_data;
  logic [15:0] s_msg_blocks;
  logic [1:0]  s_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mon_exp, mon_addr;

  sha_msg_mem #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
    .wr_last(wr_last), .wr_bytes(wr_bytes), .clr(clr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_data_vld(mem_data_vld), .msg_rdy(msg_rdy),
    .msg_blocks(msg_blocks), .err(err), .dbg_state(dbg_state)
  );

  sha_msg_mem #(.DEPTH_WORDS(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_vld(s_wr_vld), .wr_rdy(s_wr_rdy), .wr_data(s_wr_data),
    .wr_last(s_wr_last), .wr_bytes(s_wr_bytes), .clr(s_clr), .mem_addr(s_mem_addr),
    .mem_data(s_mem_data), .mem_data_vld(s_mem_data_vld), .msg_rdy(s_msg_rdy),
    .msg_blocks(s_msg_blocks), .err(s_err), .dbg_state(s_dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic write_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    wr_vld = 1'b1; wr_data = d; wr_last = last; wr_bytes = nb;
    @(posedge clk); #1;
    wr_vld = 1'b0; wr_last = 1'b0; wr_bytes = 3'd0;
  endtask

  function automatic logic [31:0] pattern(input int i);
    return 32'h03020100 + 32'h04040404 * i;
  endfunction

  task automatic load_pattern(input int n, input logic [2:0] nb);
    for (int i = 0; i < n; i++) write_word(pattern(i), (i == n - 1), nb);
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] e);
    mem_addr = a;
    @(posedge clk);
    exp_q.push_back(e);
    addr_q.push_back(a);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL read_timeout: %0d reads still pending, mem_data_vld=%0b expected 1",
               exp_q.size(), mem_data_vld);
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic s_write_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    s_wr_vld = 1'b1; s_wr_data = d; s_wr_last = last; s_wr_bytes = nb;
    @(posedge clk); #1;
    s_wr_vld = 1'b0; s_wr_last = 1'b0; s_wr_bytes = 3'd0;
  endtask

  task automatic s_do_clr();
    s_clr = 1'b1;
    @(posedge clk); #1;
    s_clr = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mem_data_vld && exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_addr = addr_q.pop_front();
      checks++;
      if (mem_data !== mon_exp) begin
        failures++;
        $display("FAIL mem_data@0x%08h: got 0x%08h expected 0x%08h", mon_addr, mem_data, mon_exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_vld = 0; wr_last = 0; wr_bytes = 0; wr_data = 0; clr = 0; mem_addr = 0;
    s_wr_vld = 0; s_wr_last = 0; s_wr_bytes = 0; s_wr_data = 0; s_clr = 0; s_mem_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_msg_rdy", msg_rdy, 0);
    chk("rst_msg_blocks", msg_blocks, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_mem_data_vld", mem_data_vld, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc"
    write_word(32'h00636261, 1'b1, 3'd3);
    chk("abc_msg_rdy", msg_rdy, 1);
    chk("abc_wr_rdy", wr_rdy, 0);
    chk("abc_blocks", msg_blocks, 1);
    chk("abc_first_vld", mem_data_vld, 0);
    read(32'd0, 32'h80636261);
    read(32'd56, 32'h00000000);
    read(32'd60, 32'h18000000);
    read(32'd2, 32'h80636261);
    drain();
    do_clr();
    chk("clr_msg_rdy", msg_rdy, 0);
    chk("clr_blocks", msg_blocks, 0);

    // L=6: bytes past wr_bytes in the final word are masked
    write_word(32'h44332211, 1'b0, 3'd0);
    write_word(32'hDDCCBBAA, 1'b1, 3'd2);
    chk("l6_blocks", msg_blocks, 1);
    read(32'd0, 32'h44332211);
    read(32'd4, 32'h0080BBAA);
    read(32'd8, 32'h00000000);
    read(32'd60, 32'h30000000);
    drain();
    do_clr();

    // L=55: largest one-block message
    load_pattern(14, 3'd3);
    chk("l55_blocks", msg_blocks, 1);
    read(32'd48, 32'h33323130);
    read(32'd52, 32'h80363534);
    read(32'd60, 32'hB8010000);
    drain();
    do_clr();

    // L=56: spills into a second block
    load_pattern(14, 3'd4);
    chk("l56_blocks", msg_blocks, 2);
    read(32'd52, 32'h37363534);
    read(32'd56, 32'h00000080);
    read(32'd60, 32'h00000000);
    read(32'd120, 32'h00000000);
    read(32'd124, 32'hC0010000);
    read(32'd128, 32'h00000000);
    drain();
    do_clr();

    // Empty message, stored word must not leak through
    write_word(32'hFFFFFFFF, 1'b1, 3'd0);
    chk("empty_blocks", msg_blocks, 1);
    read(32'd0, 32'h00000080);
    read(32'd60, 32'h00000000);
    drain();
    do_clr();

    // clr beats a same-cycle write in READY
    write_word(32'h00636261, 1'b1, 3'd3);
    clr = 1'b1; wr_vld = 1'b1; wr_data = 32'hDEADBEEF; wr_last = 1'b1; wr_bytes = 3'd4;
    @(posedge clk); #1;
    clr = 1'b0; wr_vld = 1'b0; wr_last = 1'b0; wr_bytes = 3'd0;
    chk("clrwr_wr_rdy", wr_rdy, 1);
    chk("clrwr_msg_rdy", msg_rdy, 0);
    chk("clrwr_vld", mem_data_vld, 0);
    chk("clrwr_blocks", msg_blocks, 0);
    write_word(32'h00636261, 1'b1, 3'd3);
    chk("clrwr_abc_blocks", msg_blocks, 1);
    read(32'd0, 32'h80636261);
    read(32'd60, 32'h18000000);
    drain();
    do_clr();

    // Async reset mid-load
    write_word(32'h11111111, 1'b0, 3'd0);
    write_word(32'h22222222, 1'b0, 3'd0);
    rst_n = 1'b0;
    #2;
    chk("midload_rst_wr_rdy", wr_rdy, 1);
    chk("midload_rst_msg_rdy", msg_rdy, 0);
    chk("midload_rst_vld", mem_data_vld, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-read
    write_word(32'h00636261, 1'b1, 3'd3);
    read(32'd0, 32'h80636261);
    drain();
    chk("midread_vld_before", mem_data_vld, 1);
    rst_n = 1'b0;
    #2;
    chk("midread_rst_vld", mem_data_vld, 0);
    chk("midread_rst_data", mem_data, 0);
    chk("midread_rst_msg_rdy", msg_rdy, 0);
    chk("midread_rst_wr_rdy", wr_rdy, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    write_word(32'h00636261, 1'b1, 3'd3);
    chk("reload_blocks", msg_blocks, 1);
    read(32'd0, 32'h80636261);
    read(32'd56, 32'h00000000);
    read(32'd60, 32'h18000000);
    drain();
    do_clr();

    // Overflow on the 4-word instance
    for (int i = 0; i < 4; i++) s_write_word(pattern(i), 1'b0, 3'd0);
    chk("s_full_wr_rdy", s_wr_rdy, 1);
    chk("s_full_err", s_err, 0);
    s_write_word(pattern(4), 1'b0, 3'd0);
    chk("s_ovf_err", s_err, 1);
    chk("s_ovf_wr_rdy", s_wr_rdy, 0);
    chk("s_ovf_msg_rdy", s_msg_rdy, 0);
    s_do_clr();
    chk("s_clr_err", s_err, 0);
    chk("s_clr_wr_rdy", s_wr_rdy, 1);
    for (int i = 0; i < 4; i++) s_write_word(pattern(i), 1'b0, 3'd0);
    s_write_word(pattern(4), 1'b1, 3'd0);
    chk("s_exact_msg_rdy", s_msg_rdy, 1);
    chk("s_exact_err", s_err, 0);
    chk("s_exact_blocks", s_msg_blocks, 1);
    s_do_clr();
    for (int i = 0; i < 4; i++) s_write_word(pattern(i), 1'b0, 3'd0);
    s_write_word(pattern(4), 1'b1, 3'd1);
    chk("s_lastovf_err", s_err, 1);
    chk("s_lastovf_msg_rdy", s_msg_rdy, 0);
    s_do_clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_msg_mem.md
SHA_MSG_MEM -- requirements
Module: sha_msg_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, message buffer depth in 32-bit words (max message 4*DEPTH_WORDS bytes).
REQ-002 clk  in  1  single clock, all logic rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 wr_vld  in  1  loader word valid.
REQ-005 wr_rdy  out  1  loader word accepted when wr_vld & wr_rdy.
REQ-006 wr_data  in  32  message word; byte at lowest address in [7:0].
REQ-007 wr_last  in  1  final message word.
REQ-008 wr_bytes  in  3  valid bytes in final word, 0..4 (low lanes); ignored unless wr_last.
REQ-009 clr  in  1  discard message, return to loading.
REQ-010 mem_addr  in  32  byte address from hash core, word aligned ([1:0] ignored).
REQ-011 mem_data  out  32  padded-message word for previous cycle's mem_addr.
REQ-012 mem_data_vld  out  1  mem_data valid.
REQ-013 msg_rdy  out  1  padded message available.
REQ-014 msg_blocks  out  16  number of 512-bit blocks in padded message.
REQ-015 err  out  1  sticky overflow flag.

Function
REQ-016 States LOAD, READY, ERR; LOAD after reset.
REQ-017 LOAD: wr_rdy=1; accepted word written at word index cnt, cnt increments; byte length L += 4, or += wr_bytes on wr_last.
REQ-018 Accepted wr_last in LOAD -> READY next cycle; msg_blocks = floor((L+8)/64)+1 (registered); msg_rdy=1.
REQ-019 Accepted word when cnt==DEPTH_WORDS (no wr_last, or wr_last with wr_bytes>0) -> ERR, err=1, word dropped.
REQ-020 READY and ERR: wr_rdy=0.
REQ-021 clr=1 in any state -> LOAD next cycle; cnt, L, msg_blocks, msg_rdy, err cleared; clr has priority over a same-cycle write.
REQ-022 Read path, READY only: mem_data registered, 1-cycle latency from mem_addr; mem_data_vld=1 every READY cycle after the first, 0 otherwise.
REQ-023 Byte b of padded view (b = byte address, N = 64*msg_blocks): b<L buffer byte; b==L 0x80; L<b<N-8 0x00; N-8<=b<N big-endian 64-bit bit length 8*L (byte N-1 = LSB); b>=N 0x00.
REQ-024 Buffer bytes of final word beyond wr_bytes never appear; padding rule overrides stored contents per byte.
REQ-025 mem_data lane k ([8k+7:8k]) = padded byte (mem_addr & ~3)+k.
REQ-026 Arithmetic: L 16-bit, bit length 8*L zero-extended to 64 bits; msg_blocks 16-bit, no wrap for legal DEPTH_WORDS.
REQ-027 Buffer is single-port write, single-port read; write and read never concurrent (state-exclusive).

Reset
REQ-028 rst_n low: state LOAD, cnt=0, L=0, wr_rdy=1, mem_data=0, mem_data_vld=0, msg_rdy=0, msg_blocks=0, err=0; buffer contents unspecified.
REQ-029 Reset asserted mid-load or mid-read abandons operation; outputs reach reset values without a clock edge.

Verification
REQ-030 "abc": one word 0x00636261, wr_last, wr_bytes=3 -> msg_blocks=1; addr 0 -> 0x80636261; addr 56 -> 0x00000000; addr 60 -> 0x18000000.
REQ-031 L=56 (14 full words, last with wr_bytes=4) -> msg_blocks=2; addr 56 -> 0x00000080; addr 124 -> 0xC0010000; addr 128 -> 0x00000000.
REQ-032 Empty: wr_last, wr_bytes=0 -> msg_blocks=1; addr 0 -> 0x00000080; addr 60 -> 0x00000000.
REQ-033 DEPTH_WORDS=4, five words without wr_last -> fifth accept gives err=1, wr_rdy=0, msg_rdy=0; clr -> err=0, wr_rdy=1.
REQ-034 rst_n low after 2 words loaded -> wr_rdy=1, msg_rdy=0, mem_data_vld=0 immediately; reload "abc" gives REQ-030 results.
REQ-035 READY, clr and wr_vld same cycle -> LOAD, write ignored, msg_rdy=0, mem_data_vld=0 next cycle.
